// File: rtl/mem_deco_pkg.sv
// Shared constants and the read-tag type for the CPU/VGA memory bank decoder.
// Optional feature macro: MEM_DECO_OOR_EN (sticky out-of-range error flag).
package mem_deco_pkg;

  localparam int DEF_N_BANKS = 3;
  localparam int DEF_CPU_AW  = 14;
  localparam int DEF_VGA_AW  = 16;
  localparam int DEF_BANK_AW = 12;
  localparam int DEF_RD_LAT  = 1;

  // One delay-line entry: a read is in flight, and which bank answers it.
  typedef struct packed {
    logic       valid;
    logic [7:0] sel;
  } rd_tag_t;

  // Out-of-range reads still return a valid pulse, but steer the mux to bank 0.
  function automatic rd_tag_t make_tag(input logic valid, input logic in_range,
                                       input logic [7:0] idx);
    rd_tag_t t;
    t.valid = valid;
    t.sel   = (valid && in_range) ? idx : 8'd0;
    return t;
  endfunction

endpackage

// File: rtl/mem_deco_pipe.sv
// Fixed-depth delay line for read tags; aligns the read-mux select with bank RAM data.
// Optional feature macro: MEM_DECO_OOR_EN (not used in this file).
module mem_deco_pipe
  import mem_deco_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t din,
  output rd_tag_t dout
);

  rd_tag_t stage [DEPTH];

  // Shift one tag per cycle; reset drops every in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is a register chain, not a RAM; every stage is reset so no
      // stale valid bit can surface after reset.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/mem_bank_decoder.sv
// CPU/VGA address decoder for N dual-port memory banks: bank/word split, CPU write
// enables, write-vs-scan-out collision stall, and latency-aligned read-mux selects.
// Optional feature macro: MEM_DECO_OOR_EN adds the sticky oor_err flag and err_clr.
module mem_bank_decoder
  import mem_deco_pkg::*;
#(
  parameter  int N_BANKS = DEF_N_BANKS,
  parameter  int CPU_AW  = DEF_CPU_AW,
  parameter  int VGA_AW  = DEF_VGA_AW,
  parameter  int BANK_AW = DEF_BANK_AW,
  parameter  int RD_LAT  = DEF_RD_LAT,
  localparam int SEL_W   = $clog2(N_BANKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [CPU_AW-1:0]  cpu_addr,
  output logic               cpu_gnt,
  input  logic               vga_req,
  input  logic [VGA_AW-1:0]  vga_addr,
  output logic [BANK_AW-1:0] bank_addr_cpu,
  output logic [BANK_AW-1:0] bank_addr_vga,
  output logic [N_BANKS-1:0] bank_wren,
  output logic [SEL_W-1:0]   cpu_sel,
  output logic               cpu_rvalid,
  output logic [SEL_W-1:0]   vga_sel,
  output logic               vga_rvalid
`ifdef MEM_DECO_OOR_EN
  ,
  output logic               oor_err,
  input  logic               err_clr
`endif
);

  // Bank indices are widened to 32 bits so CPU and VGA indices of different widths
  // compare directly and N_BANKS need not be a power of two.
  logic [31:0]        cpu_idx;
  logic [31:0]        vga_idx;
  logic [BANK_AW-1:0] cpu_word;
  logic [BANK_AW-1:0] vga_word;
  logic               cpu_in_range;
  logic               vga_in_range;
  logic               collision;

  assign cpu_idx      = 32'(cpu_addr[CPU_AW-1:BANK_AW]);
  assign vga_idx      = 32'(vga_addr[VGA_AW-1:BANK_AW]);
  assign cpu_word     = cpu_addr[BANK_AW-1:0];
  assign vga_word     = vga_addr[BANK_AW-1:0];
  assign cpu_in_range = cpu_idx < 32'(N_BANKS);
  assign vga_in_range = vga_idx < 32'(N_BANKS);

  // VGA scan-out is never stalled, so a CPU write to the very word being read waits.
  assign collision = cpu_req & cpu_we & vga_req &
                     (cpu_idx == vga_idx) & (cpu_word == vga_word);
  assign cpu_gnt   = cpu_req & ~collision;

  // Register bank-port addresses and the one-hot write enable for the accepted access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_addr_cpu <= '0;
      bank_addr_vga <= '0;
      bank_wren     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // independent of statement order.
      if (cpu_gnt) bank_addr_cpu <= cpu_word;
      if (vga_req) bank_addr_vga <= vga_word;
      bank_wren <= (cpu_gnt & cpu_we & cpu_in_range) ? (N_BANKS'(1) << cpu_idx) : '0;
    end
  end

  rd_tag_t cpu_tag_in;
  rd_tag_t cpu_tag_out;
  rd_tag_t vga_tag_in;
  rd_tag_t vga_tag_out;

  assign cpu_tag_in = make_tag(cpu_gnt & ~cpu_we, cpu_in_range, 8'(cpu_idx));
  assign vga_tag_in = make_tag(vga_req, vga_in_range, 8'(vga_idx));

  // One register stage for the address plus RD_LAT stages of RAM latency.
  mem_deco_pipe #(.DEPTH(1 + RD_LAT)) u_cpu_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (cpu_tag_in),
    .dout (cpu_tag_out)
  );

  mem_deco_pipe #(.DEPTH(1 + RD_LAT)) u_vga_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (vga_tag_in),
    .dout (vga_tag_out)
  );

  assign cpu_rvalid = cpu_tag_out.valid;
  assign cpu_sel    = cpu_tag_out.sel[SEL_W-1:0];
  assign vga_rvalid = vga_tag_out.valid;
  assign vga_sel    = vga_tag_out.sel[SEL_W-1:0];

  // Tag select bits above SEL_W are always zero and carry nothing.
  logic unused_sel_bits;
  assign unused_sel_bits = ^{cpu_tag_out.sel, vga_tag_out.sel};

`ifdef MEM_DECO_OOR_EN
  logic oor_hit;
  assign oor_hit = (cpu_gnt & ~cpu_in_range) | (vga_req & ~vga_in_range);

  // Sticky error flag; a new out-of-range access beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          oor_err <= 1'b0;
    else if (oor_hit) oor_err <= 1'b1;
    else if (err_clr) oor_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_mem_bank_decoder.sv
// Self-checking bench for mem_bank_decoder: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a model.
// Optional feature macro: MEM_DECO_OOR_EN (enables oor_err/err_clr checks).
module tb_mem_bank_decoder;

  localparam int N_BANKS    = 3;
  localparam int CPU_AW     = 14;
  localparam int VGA_AW     = 16;
  localparam int BANK_AW    = 12;
  localparam int RD_LAT     = 1;
  localparam int SEL_W      = 2;
  localparam int BANK_WORDS = 1 << BANK_AW;
  localparam int MAXC       = 8192;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cpu_req = 1'b0;
  logic               cpu_we = 1'b0;
  logic [CPU_AW-1:0]  cpu_addr = '0;
  logic               cpu_gnt;
  logic               vga_req = 1'b0;
  logic [VGA_AW-1:0]  vga_addr = '0;
  logic [BANK_AW-1:0] bank_addr_cpu;
  logic [BANK_AW-1:0] bank_addr_vga;
  logic [N_BANKS-1:0] bank_wren;
  logic [SEL_W-1:0]   cpu_sel;
  logic               cpu_rvalid;
  logic [SEL_W-1:0]   vga_sel;
  logic               vga_rvalid;
`ifdef MEM_DECO_OOR_EN
  logic               oor_err;
  logic               err_clr = 1'b0;
`endif

  mem_bank_decoder #(
    .N_BANKS (N_BANKS),
    .CPU_AW  (CPU_AW),
    .VGA_AW  (VGA_AW),
    .BANK_AW (BANK_AW),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_gnt       (cpu_gnt),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .bank_addr_cpu (bank_addr_cpu),
    .bank_addr_vga (bank_addr_vga),
    .bank_wren     (bank_wren),
    .cpu_sel       (cpu_sel),
    .cpu_rvalid    (cpu_rvalid),
    .vga_sel       (vga_sel),
    .vga_rvalid    (vga_rvalid)
`ifdef MEM_DECO_OOR_EN
    ,
    .oor_err       (oor_err),
    .err_clr       (err_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Grant rule in address terms: equal bank index and equal word means equal full address.
  function automatic bit model_gnt();
    return cpu_req && !(cpu_we && vga_req && (int'(cpu_addr) == int'(vga_addr)));
  endfunction

  // Reference model: expected read results are scheduled by absolute cycle number.
  int cyc = 0;
  bit exp_cv [MAXC];
  int exp_cs [MAXC];
  bit exp_vv [MAXC];
  int exp_vs [MAXC];
  int m_addr_cpu = 0;
  int m_addr_vga = 0;
  int m_wren = 0;
  bit m_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr_cpu <= 0;
      m_addr_vga <= 0;
      m_wren     <= 0;
      m_err      <= 1'b0;
      for (int i = 0; i < MAXC; i++) begin
        exp_cv[i] <= 1'b0; exp_cs[i] <= 0;
        exp_vv[i] <= 1'b0; exp_vs[i] <= 0;
      end
    end else begin
      m_wren <= (model_gnt() && cpu_we && (int'(cpu_addr) / BANK_WORDS) < N_BANKS)
                ? (1 << (int'(cpu_addr) / BANK_WORDS)) : 0;
      if (model_gnt()) m_addr_cpu <= int'(cpu_addr) % BANK_WORDS;
      if (vga_req)     m_addr_vga <= int'(vga_addr) % BANK_WORDS;
      if (cyc + 1 + RD_LAT < MAXC) begin
        if (model_gnt() && !cpu_we) begin
          exp_cv[cyc+1+RD_LAT] <= 1'b1;
          exp_cs[cyc+1+RD_LAT] <= ((int'(cpu_addr) / BANK_WORDS) < N_BANKS)
                                  ? int'(cpu_addr) / BANK_WORDS : 0;
        end
        if (vga_req) begin
          exp_vv[cyc+1+RD_LAT] <= 1'b1;
          exp_vs[cyc+1+RD_LAT] <= ((int'(vga_addr) / BANK_WORDS) < N_BANKS)
                                  ? int'(vga_addr) / BANK_WORDS : 0;
        end
      end
`ifdef MEM_DECO_OOR_EN
      if ((model_gnt() && (int'(cpu_addr) / BANK_WORDS) >= N_BANKS) ||
          (vga_req && (int'(vga_addr) / BANK_WORDS) >= N_BANKS))
        m_err <= 1'b1;
      else if (err_clr)
        m_err <= 1'b0;
`endif
      cyc <= cyc + 1;
    end
  end

  // Every-cycle comparison, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    check("cpu_gnt",       cpu_gnt,       model_gnt());
    check("bank_wren",     bank_wren,     m_wren);
    check("bank_addr_cpu", bank_addr_cpu, m_addr_cpu);
    check("bank_addr_vga", bank_addr_vga, m_addr_vga);
    check("cpu_rvalid",    cpu_rvalid,    exp_cv[cyc]);
    check("cpu_sel",       cpu_sel,       exp_cs[cyc]);
    check("vga_rvalid",    vga_rvalid,    exp_vv[cyc]);
    check("vga_sel",       vga_sel,       exp_vs[cyc]);
`ifdef MEM_DECO_OOR_EN
    check("oor_err",       oor_err,       m_err);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    vga_req = 1'b0;
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    // 1: reset held with traffic on every input, then released while idle.
    repeat (4) begin
      tick();
      cpu_req  = 1'b1;
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_addr = 14'($urandom);
      vga_req  = 1'b1;
      vga_addr = 16'($urandom_range(0, 3 * BANK_WORDS - 1));
    end
    @(negedge clk);
    check("rst_wren",       bank_wren,     0);
    check("rst_addr_cpu",   bank_addr_cpu, 0);
    check("rst_addr_vga",   bank_addr_vga, 0);
    check("rst_cpu_rvalid", cpu_rvalid,    0);
    check("rst_vga_rvalid", vga_rvalid,    0);
    tick();
    idle();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_wren",       bank_wren,  0);
      check("idle_cpu_rvalid", cpu_rvalid, 0);
      check("idle_vga_rvalid", vga_rvalid, 0);
    end

    // 2: CPU write to bank 1, word 0x005.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1005;
    @(negedge clk);
    check("t2_gnt", cpu_gnt, 1);
    tick();
    idle();
    @(negedge clk);
    check("t2_wren",   bank_wren,     3'b010);
    check("t2_addr",   bank_addr_cpu, 12'h005);
    check("t2_rvalid", cpu_rvalid,    0);

    // 3: back-to-back CPU reads from bank 2 then bank 0.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2ABC;
    tick();
    cpu_addr = 14'h0001;
    tick();
    idle();
    @(negedge clk);
    check("t3_rvalid0", cpu_rvalid,    1);
    check("t3_sel0",    cpu_sel,       2);
    check("t3_addr",    bank_addr_cpu, 12'h001);
    tick();
    @(negedge clk);
    check("t3_rvalid1", cpu_rvalid, 1);
    check("t3_sel1",    cpu_sel,    0);
    tick();
    @(negedge clk);
    check("t3_rvalid2", cpu_rvalid, 0);

    // 4: CPU write stalled by a VGA read of the same word, granted once VGA moves on.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010;
    vga_req = 1'b1; vga_addr = 16'h0010;
    @(negedge clk);
    check("t4_gnt_stall", cpu_gnt, 0);
    tick();
    vga_addr = 16'h0011;
    @(negedge clk);
    check("t4_gnt_go",   cpu_gnt,       1);
    check("t4_no_wren",  bank_wren,     0);
    check("t4_vga_addr", bank_addr_vga, 12'h010);
    tick();
    idle();
    @(negedge clk);
    check("t4_wren",       bank_wren,     3'b001);
    check("t4_addr",       bank_addr_cpu, 12'h010);
    check("t4_vga_rvalid", vga_rvalid,    1);
    check("t4_vga_sel",    vga_sel,       0);

    // 5: out-of-range CPU write is granted but writes nothing.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3000;
    @(negedge clk);
    check("t5_gnt", cpu_gnt, 1);
    tick();
    idle();
    @(negedge clk);
    check("t5_no_wren", bank_wren, 0);
`ifdef MEM_DECO_OOR_EN
    check("t5_err_set", oor_err, 1);
    tick();
    @(negedge clk);
    check("t5_err_held", oor_err, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("t5_err_clr", oor_err, 0);
`endif

    // 6: reset pulse drops an in-flight VGA read; a later read behaves normally.
    tick();
    vga_req = 1'b1; vga_addr = 16'h1FFF;
    tick();
    idle();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    check("t6_rvalid_a", vga_rvalid, 0);
    tick();
    @(negedge clk);
    check("t6_rvalid_b", vga_rvalid,    0);
    check("t6_addr_rst", bank_addr_vga, 0);
    tick();
    vga_req = 1'b1; vga_addr = 16'h1FFF;
    tick();
    idle();
    tick();
    @(negedge clk);
    check("t6_rvalid_c", vga_rvalid,    1);
    check("t6_sel_c",    vga_sel,       1);
    check("t6_addr_c",   bank_addr_vga, 12'hFFF);

    // Randomized traffic; CPU holds a stalled request, VGA often targets the CPU address.
    for (int i = 0; i < 2000; i++) begin
      bit hold;
      hold = cpu_req && !model_gnt();
      tick();
      if (!hold) begin
        cpu_req  = ($urandom_range(0, 3) != 0);
        cpu_we   = 1'($urandom_range(0, 1));
        cpu_addr = 14'($urandom);
      end
      vga_req = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       vga_addr = 16'(cpu_addr);
        1:       vga_addr = 16'($urandom);
        default: vga_addr = 16'($urandom_range(0, 4 * BANK_WORDS - 1));
      endcase
`ifdef MEM_DECO_OOR_EN
      err_clr = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    tick();
    idle();
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
